// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 sizing codes,
// responder FSM states and the MMIO console address.
package brisc_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] MMIO_CONSOLE_ADDR = 32'hFFFF_FFF0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } dmem_state_t;

    // Unsigned load codes have no store counterpart.
    function automatic logic f3_is_legal(input logic [2:0] f3, input logic we);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the core's load/store unit (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
    import brisc_mem_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_f3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_f3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_f3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_responder_array.sv
// Word-wide synchronous-read RAM with per-byte write enables. Contents are
// never reset.
module dmem_array
    import brisc_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [3:0]    wr_be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (rd_en) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with funct3 sizing, optional wait
// states and error reporting. Define DMEM_MMIO_EN to add the console MMIO port.
module dmem_responder
    import brisc_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 0
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
`ifdef DMEM_MMIO_EN
    ,
    output logic            mmio_valid,
    output logic [7:0]      mmio_data
`endif
);

    localparam int         AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        accept;
    logic [1:0]  lane;
    logic        in_range;
    logic        misaligned;
    logic        mmio_hit;
    logic        err_w;
    logic [3:0]  be;
    logic [31:0] store_data;
    logic [3:0]  ram_be;
    logic        ram_re;
    logic [31:0] ram_rdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign bus.req_ready = rst && (state_q == IDLE);
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Decode of the captured request; stable from capture until the response.
    assign lane     = addr_q[1:0];
    assign in_range = ({2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS));

    always_comb begin
        misaligned = 1'b0;
        case (f3_q[1:0])
            2'b01:   misaligned = addr_q[0];
            2'b10:   misaligned = |addr_q[1:0];
            default: misaligned = 1'b0;
        endcase
    end

`ifdef DMEM_MMIO_EN
    assign mmio_hit = (addr_q == MMIO_CONSOLE_ADDR) &&
                      (we_q ? (f3_q == F3_B || f3_q == F3_W) : f3_is_legal(f3_q, 1'b0));
    assign mmio_valid = (state_q == ACCESS) && we_q && mmio_hit;
    assign mmio_data  = mmio_valid ? wdata_q[7:0] : 8'h00;
`else
    assign mmio_hit = 1'b0;
`endif

    assign err_w = !mmio_hit && (!f3_is_legal(f3_q, we_q) || misaligned || !in_range);

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be         = 4'b1111;
        store_data = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                be         = 4'b0001 << lane;
                store_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be         = addr_q[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata_q[15:0]}};
            end
            default: begin
                be         = 4'b1111;
                store_data = wdata_q;
            end
        endcase
    end

    assign ram_be = ((state_q == ACCESS) && we_q && !err_w && !mmio_hit) ? be : 4'b0000;
    assign ram_re = (state_q == ACCESS) && !we_q;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .rd_en(ram_re),
        .wr_be(ram_be),
        .addr (addr_q[AW+1:2]),
        .wdata(store_data),
        .rdata(ram_rdata)
    );

    assign byte_sel = ram_rdata[{lane, 3'b000} +: 8];
    assign half_sel = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];

    always_comb begin
        load_data = 32'h0;
        if (!we_q && !err_w && !mmio_hit) begin
            case (f3_q)
                F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
                F3_BU:   load_data = {24'h0, byte_sel};
                F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
                F3_HU:   load_data = {16'h0, half_sel};
                F3_W:    load_data = ram_rdata;
                default: load_data = 32'h0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (LATENCY > 0) ? WAIT : ACCESS;
                    cnt_d   = LAT_M1;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                // First RESP cycle registers the RAM output; afterwards hold until taken.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_data;
                    rsp_err_d   = err_w;
                end else if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            f3_q        <= 3'b000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                f3_q    <= bus.req_f3;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (no wait states and three wait
// states) checked every cycle against a transaction-level memory model.
`timescale 1ns/1ps
module tb_dmem_responder;
    import brisc_mem_pkg::*;

    localparam int DEPTH = 64;

    logic clk;
    logic rst;

    logic        req_valid [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [2:0]  req_f3    [2];
    logic        rsp_ready [2];
    logic        req_ready_s [2];
    logic        rsp_valid_s [2];
    logic [31:0] rsp_rdata_s [2];
    logic        rsp_err_s   [2];
`ifdef DMEM_MMIO_EN
    logic        mmio_valid_s [2];
    logic [7:0]  mmio_data_s  [2];
`endif

    dmem_responder_if if0 ();
    dmem_responder_if if3 ();

    assign if0.req_valid = req_valid[0];
    assign if0.req_we    = req_we[0];
    assign if0.req_addr  = req_addr[0];
    assign if0.req_wdata = req_wdata[0];
    assign if0.req_f3    = req_f3[0];
    assign if0.rsp_ready = rsp_ready[0];
    assign req_ready_s[0] = if0.req_ready;
    assign rsp_valid_s[0] = if0.rsp_valid;
    assign rsp_rdata_s[0] = if0.rsp_rdata;
    assign rsp_err_s[0]   = if0.rsp_err;

    assign if3.req_valid = req_valid[1];
    assign if3.req_we    = req_we[1];
    assign if3.req_addr  = req_addr[1];
    assign if3.req_wdata = req_wdata[1];
    assign if3.req_f3    = req_f3[1];
    assign if3.rsp_ready = rsp_ready[1];
    assign req_ready_s[1] = if3.req_ready;
    assign rsp_valid_s[1] = if3.rsp_valid;
    assign rsp_rdata_s[1] = if3.rsp_rdata;
    assign rsp_err_s[1]   = if3.rsp_err;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(if0)
`ifdef DMEM_MMIO_EN
        , .mmio_valid(mmio_valid_s[0]), .mmio_data(mmio_data_s[0])
`endif
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .bus(if3)
`ifdef DMEM_MMIO_EN
        , .mmio_valid(mmio_valid_s[1]), .mmio_data(mmio_data_s[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Behavioural model state
    logic [31:0] mem_m [2][DEPTH];
    bit          busy   [2];
    int          acc    [2];
    logic [31:0] exp_rd [2];
    bit          exp_er [2];
    bit          st_do  [2];
    logic [31:0] st_addr  [2];
    logic [31:0] st_wdata [2];
    logic [2:0]  st_f3    [2];
    bit          exp_mmio [2];
    logic [7:0]  exp_mdat [2];

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit legal_f3(input logic [2:0] f3);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic bit is_mmio(input bit we, input logic [31:0] addr, input logic [2:0] f3);
`ifdef DMEM_MMIO_EN
        if (addr != 32'hFFFF_FFF0) return 1'b0;
        if (we) return (f3 == 3'd0) || (f3 == 3'd2);
        return legal_f3(f3);
`else
        return (we && addr == 32'h1) && (f3 == 3'd7) && 1'b0;
`endif
    endfunction

    function automatic bit is_err(input bit we, input logic [31:0] addr, input logic [2:0] f3);
        int sz;
        sz = size_of(f3);
        if (is_mmio(we, addr, f3)) return 1'b0;
        if (!legal_f3(f3)) return 1'b1;
        if (we && f3[2]) return 1'b1;
        if ((int'(addr[1:0]) % sz) != 0) return 1'b1;
        if (addr[31:2] >= 30'(DEPTH)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] load_val(input int d, input logic [31:0] addr, input logic [2:0] f3);
        logic [31:0] v, mask;
        int sz;
        sz = size_of(f3);
        v  = mem_m[d][int'(addr[31:2])] >> (8 * int'(addr[1:0]));
        if (sz < 4) begin
            mask = (32'h1 << (8 * sz)) - 32'h1;
            v = v & mask;
            if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on every active edge
    initial forever begin
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            int l;
            l = lat_of(d);
            if (!rst) begin
                busy[d] = 1'b0;
            end else if (busy[d]) begin
                if (cyc == acc[d] + l + 1 && st_do[d]) begin
                    for (int b = 0; b < size_of(st_f3[d]); b++) begin
                        int p;
                        p = int'(st_addr[d][1:0]) + b;
                        mem_m[d][int'(st_addr[d][31:2])][8*p +: 8] = st_wdata[d][8*b +: 8];
                    end
                end
                if (cyc - 1 >= acc[d] + l + 2 && rsp_ready[d]) busy[d] = 1'b0;
            end else if (req_valid[d]) begin
                bit e, m;
                busy[d]     = 1'b1;
                acc[d]      = cyc;
                e           = is_err(req_we[d], req_addr[d], req_f3[d]);
                m           = is_mmio(req_we[d], req_addr[d], req_f3[d]);
                exp_er[d]   = e;
                exp_rd[d]   = (req_we[d] || e || m) ? 32'h0 : load_val(d, req_addr[d], req_f3[d]);
                st_do[d]    = req_we[d] && !e && !m;
                st_addr[d]  = req_addr[d];
                st_wdata[d] = req_wdata[d];
                st_f3[d]    = req_f3[d];
                exp_mmio[d] = req_we[d] && m;
                exp_mdat[d] = req_wdata[d][7:0];
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    initial forever begin
        @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            bit ev;
            ev = busy[d] && (cyc >= acc[d] + lat_of(d) + 2);
            chk1($sformatf("dut%0d req_ready", d), req_ready_s[d], rst && !busy[d]);
            chk1($sformatf("dut%0d rsp_valid", d), rsp_valid_s[d], ev);
            if (ev) begin
                chk($sformatf("dut%0d rsp_rdata", d), rsp_rdata_s[d], exp_rd[d]);
                chk1($sformatf("dut%0d rsp_err", d), rsp_err_s[d], exp_er[d]);
            end
`ifdef DMEM_MMIO_EN
            begin
                bit em;
                em = busy[d] && (cyc == acc[d] + lat_of(d)) && exp_mmio[d];
                chk1($sformatf("dut%0d mmio_valid", d), mmio_valid_s[d], em);
                if (em) chk($sformatf("dut%0d mmio_data", d), {24'h0, mmio_data_s[d]}, {24'h0, exp_mdat[d]});
            end
`endif
        end
    end

`ifdef DMEM_MMIO_EN
    int         mmio_cnt = 0;
    logic [7:0] mmio_last = 8'h00;
    initial forever begin
        @(posedge clk);
        #2;
        if (mmio_valid_s[0] === 1'b1) begin
            mmio_cnt++;
            mmio_last = mmio_data_s[0];
        end
    end
`endif

    task automatic issue(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, output int acc_c);
        int n;
        n = 0;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_f3[d]    = f3;
        while (req_ready_s[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL dut%0d accept timeout: req_ready=%b required 1", d, req_ready_s[d]);
            req_valid[d] = 1'b0;
            acc_c = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc_c = cyc;
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
    endtask

    task automatic collect(input int d, input int delay, input int acc_c,
                           output logic [31:0] rd, output logic er, output int lat);
        int held, waited;
        held = 0;
        waited = 0;
        lat = -1;
        forever begin
            if (rsp_valid_s[d] === 1'b1) begin
                if (lat < 0) lat = cyc - acc_c;
                if (held >= delay) break;
                held++;
            end
            if (waited >= 100) begin
                checks++;
                errors++;
                $display("FAIL dut%0d response timeout: rsp_valid=%b required 1", d, rsp_valid_s[d]);
                rd = 32'h0;
                er = 1'b0;
                return;
            end
            @(negedge clk);
            waited++;
        end
        rd = rsp_rdata_s[d];
        er = rsp_err_s[d];
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
    endtask

    task automatic do_txn(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input int delay,
                          output logic [31:0] rd, output logic er, output int lat);
        int acc_c;
        issue(d, we, addr, wdata, f3, acc_c);
        if (acc_c < 0) begin
            rd = 32'h0;
            er = 1'b0;
            lat = -1;
            return;
        end
        collect(d, delay, acc_c, rd, er, lat);
        $display("txn dut%0d %s f3=%0d addr=%08h wdata=%08h -> rdata=%08h err=%0d lat=%0d",
                 d, we ? "ST" : "LD", f3, addr, wdata, rd, er, lat);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acc_c;

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = 32'h0;
            req_wdata[d] = 32'h0;
            req_f3[d]    = 3'd0;
            rsp_ready[d] = 1'b0;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk1($sformatf("reset dut%0d req_ready", d), req_ready_s[d], 1'b0);
            chk1($sformatf("reset dut%0d rsp_valid", d), rsp_valid_s[d], 1'b0);
            chk1($sformatf("reset dut%0d rsp_err", d), rsp_err_s[d], 1'b0);
            chk($sformatf("reset dut%0d rsp_rdata", d), rsp_rdata_s[d], 32'h0);
        end
        rst = 1'b1;
        @(negedge clk);

        // Give every word a defined value so loads are always predictable
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < DEPTH; w++)
                do_txn(d, 1'b1, 32'(w * 4), $urandom, F3_W, 0, rd, er, lat);

        do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, F3_W, 0, rd, er, lat);
        chk("sw latency", 32'(lat), 32'd2);
        do_txn(0, 1'b0, 32'h10, 32'h0, F3_W, 0, rd, er, lat);
        chk("lw 0x10", rd, 32'hDEADBEEF);
        chk1("lw 0x10 err", er, 1'b0);
        chk("lw latency", 32'(lat), 32'd2);

        do_txn(0, 1'b1, 32'h13, 32'h0000_0080, F3_B, 0, rd, er, lat);
        do_txn(0, 1'b0, 32'h13, 32'h0, F3_B, 1, rd, er, lat);
        chk("lb 0x13", rd, 32'hFFFFFF80);
        do_txn(0, 1'b0, 32'h13, 32'h0, F3_BU, 0, rd, er, lat);
        chk("lbu 0x13", rd, 32'h00000080);
        do_txn(0, 1'b0, 32'h10, 32'h0, F3_W, 2, rd, er, lat);
        chk("lw after sb", rd, 32'h80ADBEEF);

        do_txn(0, 1'b0, 32'h11, 32'h0, F3_H, 0, rd, er, lat);
        chk1("lh misaligned err", er, 1'b1);
        chk("lh misaligned rdata", rd, 32'h0);
        do_txn(0, 1'b1, 32'h12, 32'h1234_5678, F3_W, 0, rd, er, lat);
        chk1("sw misaligned err", er, 1'b1);
        chk("sw misaligned rdata", rd, 32'h0);
        do_txn(0, 1'b0, 32'h10, 32'h0, F3_W, 0, rd, er, lat);
        chk("lw unchanged", rd, 32'h80ADBEEF);

        do_txn(1, 1'b1, 32'h30, 32'hCAFE_F00D, F3_W, 4, rd, er, lat);
        chk("lat3 sw latency", 32'(lat), 32'd5);
        do_txn(1, 1'b0, 32'h30, 32'h0, F3_W, 4, rd, er, lat);
        chk("lat3 lw", rd, 32'hCAFE_F00D);
        chk("lat3 lw latency", 32'(lat), 32'd5);

        do_txn(1, 1'b1, 32'h20, 32'h1234_5678, F3_W, 0, rd, er, lat);
        issue(1, 1'b1, 32'h20, 32'h0000_0001, F3_W, acc_c);
        rst = 1'b0;
        #1;
        chk1("abort rsp_valid", rsp_valid_s[1], 1'b0);
        chk1("abort req_ready", req_ready_s[1], 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_txn(1, 1'b0, 32'h20, 32'h0, F3_W, 0, rd, er, lat);
        chk("abort old value", rd, 32'h1234_5678);

`ifdef DMEM_MMIO_EN
        begin
            int before;
            before = mmio_cnt;
            do_txn(0, 1'b1, 32'hFFFF_FFF0, 32'h0000_0041, F3_B, 0, rd, er, lat);
            chk1("mmio sb err", er, 1'b0);
            chk("mmio pulses", 32'(mmio_cnt - before), 32'd1);
            chk("mmio data", {24'h0, mmio_last}, 32'h41);
            do_txn(0, 1'b0, 32'hFFFF_FFF0, 32'h0, F3_W, 0, rd, er, lat);
            chk1("mmio lw err", er, 1'b0);
            chk("mmio lw rdata", rd, 32'h0);
        end
`else
        do_txn(0, 1'b1, 32'hFFFF_FFF0, 32'h0000_0041, F3_B, 0, rd, er, lat);
        chk1("console sb out of range", er, 1'b1);
`endif

        for (int i = 0; i < 200; i++) begin
            int d, r;
            bit we;
            logic [2:0]  f3;
            logic [31:0] addr;
            d  = int'($urandom_range(1, 0));
            we = 1'($urandom_range(1, 0));
            f3 = 3'($urandom_range(7, 0));
            r  = int'($urandom_range(15, 0));
            if (r == 0)      addr = $urandom;
            else if (r == 1) addr = 32'hFFFF_FFF0;
            else             addr = 32'($urandom_range(DEPTH * 4 - 1, 0));
            do_txn(d, we, addr, $urandom, f3, int'($urandom_range(3, 0)), rd, er, lat);
            chk($sformatf("random dut%0d latency", d), 32'(lat), 32'(lat_of(d) + 2));
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
